// File: rtl/bus_load_ctrl_if.sv
// Transfer and RAM-write channel for bus_load_ctrl.
// The transfer side carries the bus value, its destination code and the
// valid/ready handshake; the memory side carries the write request, the
// captured address/data and the acknowledge returned by the RAM.
interface bus_load_ctrl_if;
  logic [7:0] bus;
  logic [2:0] ld;
  logic       valid;
  logic       ready;
  logic       mem_we;
  logic       mem_ack;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;

  // Environment side: drives transfers and answers RAM writes.
  modport master (
    output bus, ld, valid, mem_ack,
    input  ready, mem_we, mem_addr, mem_wdata
  );

  // Controller side: accepts transfers and issues RAM writes.
  modport slave (
    input  bus, ld, valid, mem_ack,
    output ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bus_load_ctrl.sv
// Bus load controller: routes the common bus value into the architectural
// registers (AR, PC, DR, AC, IR) according to a destination code, applies
// per-cycle register micro-ops, and runs a single outstanding RAM write with
// an acknowledge timeout. Any reserved destination code or a write timeout
// raises a sticky error flag that only reset clears.
module bus_load_ctrl #(
  // Cycles spent waiting for mem_ack before the write is abandoned (1..255).
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_load_ctrl_if.slave    bif,
  input  logic              inc_ar_i,
  input  logic              inc_pc_i,
  input  logic              clr_ac_i,
  output logic [3:0]        ar_o,
  output logic [3:0]        pc_o,
  output logic [7:0]        dr_o,
  output logic [7:0]        ac_o,
  output logic [7:0]        ir_o,
  output logic              err_o
);

  // Destination codes carried on ld; the value doubles as the bit index
  // into the one-hot select vector below.
  localparam int LD_NONE = 0;
  localparam int LD_AR   = 1;
  localparam int LD_PC   = 2;
  localparam int LD_DR   = 3;
  localparam int LD_AC   = 4;
  localparam int LD_IR   = 5;
  localparam int LD_RAM  = 6;
  localparam int LD_RSVD = 7;

  // Counter value on which an unacknowledged write is given up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ar_q, ar_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] dr_q, dr_d;
  logic [7:0] ac_q, ac_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] maddr_q, maddr_d;
  logic [7:0] mwdata_q, mwdata_d;
  logic       mem_we_q, mem_we_d;
  logic       err_q, err_d;

  logic       accept;
  logic [7:0] ld_sel;

  // A transfer is taken only while idle; ld_sel is one-hot on the accepted
  // destination and all-zero otherwise, so ignored transfers cannot leak.
  assign accept = bif.valid && (state_q == S_IDLE);
  assign ld_sel = accept ? (8'b1 << bif.ld) : 8'b0;

  // Architectural register next state: an accepted load beats the
  // micro-op aimed at the same register in the same cycle.
  always_comb begin
    ar_d = ar_q;
    pc_d = pc_q;
    dr_d = dr_q;
    ac_d = ac_q;
    ir_d = ir_q;

    if (ld_sel[LD_AR]) begin
      ar_d = bif.bus[3:0];
    end else if (inc_ar_i) begin
      ar_d = ar_q + 4'd1;
    end

    if (ld_sel[LD_PC]) begin
      pc_d = bif.bus[3:0];
    end else if (inc_pc_i) begin
      pc_d = pc_q + 4'd1;
    end

    if (ld_sel[LD_AC]) begin
      ac_d = bif.bus;
    end else if (clr_ac_i) begin
      ac_d = 8'h00;
    end

    if (ld_sel[LD_DR]) begin
      dr_d = bif.bus;
    end

    if (ld_sel[LD_IR]) begin
      ir_d = bif.bus;
    end
  end

  // Write FSM next state: capture address/data on entry, then leave on
  // acknowledge or when the wait budget runs out (ack wins a tie).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mem_we_d = mem_we_q;
    err_d    = err_q | ld_sel[LD_RSVD];

    case (state_q)
      S_IDLE: begin
        if (ld_sel[LD_RAM]) begin
          state_d  = S_WRITE;
          maddr_d  = ar_q;
          mwdata_d = bif.bus;
          mem_we_d = 1'b1;
          cnt_d    = 8'd0;
        end
      end
      S_WRITE: begin
        if (bif.mem_ack) begin
          state_d  = S_IDLE;
          mem_we_d = 1'b0;
          cnt_d    = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_IDLE;
          mem_we_d = 1'b0;
          cnt_d    = 8'd0;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        mem_we_d = 1'b0;
        cnt_d    = 8'd0;
      end
    endcase
  end

  // State register; reset wins over every load, micro-op and acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ar_q     <= 4'h0;
      pc_q     <= 4'h0;
      dr_q     <= 8'h00;
      ac_q     <= 8'h00;
      ir_q     <= 8'h00;
      maddr_q  <= 4'h0;
      mwdata_q <= 8'h00;
      mem_we_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ar_q     <= ar_d;
      pc_q     <= pc_d;
      dr_q     <= dr_d;
      ac_q     <= ac_d;
      ir_q     <= ir_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mem_we_q <= mem_we_d;
      err_q    <= err_d;
    end
  end

  assign bif.ready     = (state_q == S_IDLE);
  assign bif.mem_we    = mem_we_q;
  assign bif.mem_addr  = maddr_q;
  assign bif.mem_wdata = mwdata_q;

  assign ar_o  = ar_q;
  assign pc_o  = pc_q;
  assign dr_o  = dr_q;
  assign ac_o  = ac_q;
  assign ir_o  = ir_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_bus_load_ctrl.sv
// Testbench for bus_load_ctrl: a directed vector table, hand-written
// timeout and reset-during-write sequences, then randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_bus_load_ctrl;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic inc_ar, inc_pc, clr_ac;
  logic [3:0] ar, pc;
  logic [7:0] dr, ac, ir;
  logic err;

  bus_load_ctrl_if bif ();

  bus_load_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bif      (bif),
    .inc_ar_i (inc_ar),
    .inc_pc_i (inc_pc),
    .clr_ac_i (clr_ac),
    .ar_o     (ar),
    .pc_o     (pc),
    .dr_o     (dr),
    .ac_o     (ac),
    .ir_o     (ir),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ar;
    logic [3:0] pc;
    logic [7:0] dr;
    logic [7:0] ac;
    logic [7:0] ir;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       rdy;
    logic       err;
  } obs_t;

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] ld;
    logic [7:0] bus;
    logic       ia, ip, ca, ak;
    obs_t       exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  // Behavioural model state
  int  m_ar, m_pc, m_dr, m_ac, m_ir, m_addr, m_wd, m_budget;
  bit  m_busy, m_err;

  function automatic vec_t mk(logic r, logic v, logic [2:0] ld, logic [7:0] bus,
                              logic ia, logic ip, logic ca, logic ak,
                              logic [3:0] e_ar, logic [3:0] e_pc, logic [7:0] e_dr,
                              logic [7:0] e_ac, logic [7:0] e_ir, logic e_we,
                              logic [3:0] e_addr, logic [7:0] e_wd, logic e_rdy, logic e_err);
    vec_t t;
    t.r = r; t.v = v; t.ld = ld; t.bus = bus;
    t.ia = ia; t.ip = ip; t.ca = ca; t.ak = ak;
    t.exp = '{ar: e_ar, pc: e_pc, dr: e_dr, ac: e_ac, ir: e_ir, we: e_we,
              addr: e_addr, wd: e_wd, rdy: e_rdy, err: e_err};
    return t;
  endfunction

  function automatic obs_t dut_obs();
    return '{ar: ar, pc: pc, dr: dr, ac: ac, ir: ir, we: bif.mem_we,
             addr: bif.mem_addr, wd: bif.mem_wdata, rdy: bif.ready, err: err};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ar=%h pc=%h dr=%h ac=%h ir=%h we=%b addr=%h wd=%h rdy=%b err=%b",
                     o.ar, o.pc, o.dr, o.ac, o.ir, o.we, o.addr, o.wd, o.rdy, o.err);
  endfunction

  task automatic check_obs(string name, int idx, obs_t exp);
    obs_t act;
    act = dut_obs();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %s | want %s", name, idx, fmt(act), fmt(exp));
    end else begin
      $display("ok   %s #%0d: %s", name, idx, fmt(act));
    end
  endtask

  task automatic check_val(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %h want %h", name, idx, act, exp);
    end else begin
      $display("ok   %s #%0d: %h", name, idx, act);
    end
  endtask

  task automatic drive(logic r, logic v, logic [2:0] ld, logic [7:0] bus,
                       logic ia, logic ip, logic ca, logic ak);
    rst_n      = r;
    bif.valid  = v;
    bif.ld     = ld;
    bif.bus    = bus;
    inc_ar     = ia;
    inc_pc     = ip;
    clr_ac     = ca;
    bif.mem_ack = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: one clock of the controller's documented behaviour. A write
  // holds a remaining-cycle budget that is spent one unit per unacked cycle.
  task automatic model_step(logic r, logic v, logic [2:0] ld, logic [7:0] bus,
                            logic ia, logic ip, logic ca, logic ak);
    bit take;
    int old_ar;
    if (!r) begin
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0;
      m_addr = 0; m_wd = 0; m_busy = 0; m_err = 0; m_budget = 0;
      return;
    end
    take   = v && !m_busy;
    old_ar = m_ar;
    if (ia) m_ar = (m_ar + 1) % 16;
    if (ip) m_pc = (m_pc + 1) % 16;
    if (ca) m_ac = 0;
    if (take) begin
      case (int'(ld))
        1: m_ar = int'(bus) % 16;
        2: m_pc = int'(bus) % 16;
        3: m_dr = int'(bus);
        4: m_ac = int'(bus);
        5: m_ir = int'(bus);
        7: m_err = 1;
        default: ;
      endcase
    end
    if (m_busy) begin
      if (ak) begin
        m_busy = 0;
      end else begin
        m_budget = m_budget - 1;
        if (m_budget == 0) begin
          m_busy = 0;
          m_err  = 1;
        end
      end
    end else if (take && ld == 3'd6) begin
      m_busy   = 1;
      m_budget = TO;
      m_addr   = old_ar;
      m_wd     = int'(bus);
    end
  endtask

  function automatic obs_t model_obs();
    return '{ar: 4'(m_ar), pc: 4'(m_pc), dr: 8'(m_dr), ac: 8'(m_ac), ir: 8'(m_ir),
             we: m_busy, addr: 4'(m_addr), wd: 8'(m_wd), rdy: !m_busy, err: m_err};
  endfunction

  initial begin
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- directed vector table ----------------
    //            r v ld    bus   ia ip ca ak  ar    pc    dr     ac     ir    we addr  wd    rdy err
    vecs.push_back(mk(0,1,3'd3,8'hFF,1,1,1,1, 4'h0,4'h0,8'h00,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,3'd3,8'hA5,0,0,0,0, 4'h0,4'h0,8'hA5,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,3'd1,8'hFF,0,0,0,0, 4'hF,4'h0,8'hA5,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,1,0,0,0, 4'h0,4'h0,8'hA5,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,3'd1,8'h37,1,0,0,0, 4'h7,4'h0,8'hA5,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,3'd1,8'h03,0,0,0,0, 4'h3,4'h0,8'hA5,8'h00,8'h00,0,4'h0,8'h00,1,0));
    vecs.push_back(mk(1,1,3'd6,8'h5C,1,0,0,0, 4'h4,4'h0,8'hA5,8'h00,8'h00,1,4'h3,8'h5C,0,0));
    vecs.push_back(mk(1,1,3'd4,8'hFF,1,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h00,1,4'h3,8'h5C,0,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h00,1,4'h3,8'h5C,0,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,0,0,1, 4'h5,4'h0,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,0,0,1, 4'h5,4'h0,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,1,3'd4,8'h81,0,0,1,0, 4'h5,4'h0,8'hA5,8'h81,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,0,1,0, 4'h5,4'h0,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,1,3'd2,8'hAE,0,1,0,0, 4'h5,4'hE,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,1,0,0, 4'h5,4'hF,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,1,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h00,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,1,3'd5,8'h3C,0,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h3C,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,1,3'd0,8'h77,0,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h3C,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,0,3'd3,8'h11,0,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h3C,0,4'h3,8'h5C,1,0));
    vecs.push_back(mk(1,1,3'd7,8'h99,0,0,0,0, 4'h5,4'h0,8'hA5,8'h00,8'h3C,0,4'h3,8'h5C,1,1));
    vecs.push_back(mk(1,1,3'd3,8'h42,0,0,0,0, 4'h5,4'h0,8'h42,8'h00,8'h3C,0,4'h3,8'h5C,1,1));
    vecs.push_back(mk(1,1,3'd6,8'h9D,0,0,0,0, 4'h5,4'h0,8'h42,8'h00,8'h3C,1,4'h5,8'h9D,0,1));
    vecs.push_back(mk(1,0,3'd0,8'h00,0,0,0,1, 4'h5,4'h0,8'h42,8'h00,8'h3C,0,4'h5,8'h9D,1,1));
    vecs.push_back(mk(1,1,3'd6,8'h01,0,0,0,0, 4'h5,4'h0,8'h42,8'h00,8'h3C,1,4'h5,8'h01,0,1));
    vecs.push_back(mk(1,1,3'd1,8'h0A,0,0,0,1, 4'h5,4'h0,8'h42,8'h00,8'h3C,0,4'h5,8'h01,1,1));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].ld, vecs[i].bus,
            vecs[i].ia, vecs[i].ip, vecs[i].ca, vecs[i].ak);
      tick();
      check_obs("vec", i, vecs[i].exp);
    end

    // ---------------- write timeout ----------------
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("to_reset_err", 0, 32'(err), 32'd0);
    drive(1'b1, 1'b1, 3'd1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 3'd6, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("to_start_we_addr_wd", 0, {19'd0, bif.mem_we, bif.mem_addr, bif.mem_wdata},
              {19'd0, 1'b1, 4'h9, 8'h66});
    for (int k = 1; k <= TO; k++) begin
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      if (k < TO)
        check_val("to_wait_we_err_rdy", k, {29'd0, bif.mem_we, err, bif.ready}, 32'b100);
      else
        check_val("to_abort_we_err_rdy", k, {29'd0, bif.mem_we, err, bif.ready}, 32'b011);
    end
    drive(1'b1, 1'b1, 3'd3, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("to_after_dr_err", 0, {23'd0, dr, err}, {23'd0, 8'h12, 1'b1});

    // ---------------- reset during write ----------------
    drive(1'b1, 1'b1, 3'd6, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_val("rw_busy_we", 0, 32'(bif.mem_we), 32'd1);
    drive(1'b0, 1'b1, 3'd1, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check_obs("rw_reset", 0, '{ar: 4'h0, pc: 4'h0, dr: 8'h00, ac: 8'h00, ir: 8'h00,
                               we: 1'b0, addr: 4'h0, wd: 8'h00, rdy: 1'b1, err: 1'b0});

    // ---------------- randomized traffic vs model ----------------
    model_step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic       r, v, ia, ip, ca, ak;
      logic [2:0] l;
      logic [7:0] b;
      r  = ($urandom_range(63) != 0);
      v  = 1'($urandom_range(1));
      l  = 3'($urandom_range(7));
      b  = 8'($urandom);
      ia = ($urandom_range(3) == 0);
      ip = ($urandom_range(3) == 0);
      ca = ($urandom_range(5) == 0);
      ak = ($urandom_range(9) == 0);
      drive(r, v, l, b, ia, ip, ca, ak);
      model_step(r, v, l, b, ia, ip, ca, ak);
      tick();
      check_obs("rand", i, model_obs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_load_ctrl.md
BUS_LOAD_CTRL -- requirements
Module: bus_load_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles spent in WRITE waiting for mem_ack before abort (range 1-255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 BUS  input  8  common bus value driven by the bus selector.
REQ-005 LD  input  3  destination: 000 none, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 RAM write, 111 reserved.
REQ-006 valid  input  1  transfer strobe; qualifies BUS and LD.
REQ-007 ready  output  1  block can accept a transfer this cycle.
REQ-008 INC_AR, INC_PC, CLR_AC  input  1 each  register micro-ops.
REQ-009 mem_ack  input  1  RAM write acknowledge.
REQ-010 mem_we  output  1  RAM write request, held until ack or abort.
REQ-011 mem_addr  output  4  captured write address; mem_wdata  output  8  captured write data.
REQ-012 AR, PC  output  4 each; DR, AC, IR  output  8 each  architectural registers.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 A transfer SHALL be accepted on a rising edge where valid=1 and ready=1; otherwise LD and BUS are ignored.
REQ-015 An accepted LD of 001/010 SHALL load BUS[3:0] into AR/PC; 011/100/101 SHALL load BUS[7:0] into DR/AC/IR; new value is visible one cycle after acceptance.
REQ-016 An accepted LD=000 SHALL be a no-op with no register change.
REQ-017 An accepted LD=111 SHALL change no register and SHALL set err.
REQ-018 INC_AR/INC_PC SHALL add 1 modulo 16 (4'hF wraps to 4'h0); CLR_AC SHALL set AC to 8'h00; each acts every cycle regardless of valid/ready.
REQ-019 When an accepted load targets the same register as an asserted INC_AR, INC_PC or CLR_AC in the same cycle, the load SHALL win and the micro-op SHALL be dropped.
REQ-020 FSM states: IDLE, WRITE; ready=1 exactly in IDLE.
REQ-021 IDLE -> WRITE on accepted LD=110: mem_addr<=AR (pre-increment value in that cycle), mem_wdata<=BUS, mem_we<=1, timeout counter<=0.
REQ-022 In WRITE, mem_addr and mem_wdata SHALL stay stable; later AR changes SHALL NOT affect them.
REQ-023 WRITE -> IDLE on the edge where mem_ack=1: mem_we<=0, ready<=1.
REQ-024 In WRITE without mem_ack, counter SHALL increment each cycle; on the edge where counter reaches ACK_TIMEOUT-1 without ack, the block SHALL go to IDLE, drop mem_we and set err.
REQ-025 mem_ack while in IDLE SHALL be ignored.
REQ-026 err SHALL remain 1 once set until reset.
REQ-027 Minimum write occupancy: mem_we high for at least one cycle; back-to-back writes SHALL have ready=1 for at least one cycle between them.

Reset
REQ-028 On a rising edge with rst_n=0: AR, PC=4'h0; DR, AC, IR=8'h00; mem_addr=4'h0, mem_wdata=8'h00; mem_we=0; err=0; state IDLE; ready=1; counter=0.
REQ-029 Reset during WRITE SHALL abort the write: mem_we=0 after that edge, no err set.
REQ-030 Reset SHALL override all simultaneous loads, micro-ops and acks.

Verification
REQ-031 Reset, then valid=1 LD=011 BUS=8'hA5 -> next cycle DR=8'hA5, other registers 0, ready=1.
REQ-032 AR=4'hF, INC_AR=1 for one cycle -> AR=4'h0; same cycle LD=001 BUS=8'h37 with INC_AR=1 -> AR=4'h7.
REQ-033 AR=4'h3, valid LD=110 BUS=8'h5C, INC_AR=1 same cycle -> mem_we=1, mem_addr=4'h3, mem_wdata=8'h5C, AR=4'h4, ready=0; mem_ack after 3 cycles -> mem_we=0, ready=1, err=0.
REQ-034 LD=110 accepted with mem_ack held 0 -> mem_we drops and err=1 after ACK_TIMEOUT cycles (15); err stays 1 through later normal transfers.
REQ-035 During WRITE, valid=1 LD=100 BUS=8'hFF -> AC unchanged; valid LD=111 in IDLE -> err=1, no register change.
REQ-036 rst_n=0 for one cycle mid-WRITE -> mem_we=0, ready=1, all registers 0, err=0.
